// File: rtl/rv32i_mem_pkg.sv
// Shared types and helpers for the I-cache line refill responder.
package rv32i_mem_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_READ,
    S_DRAIN,
    S_RESP
  } fill_state_e;

  // Width of one assembled cache line in bits.
  function automatic int LINE_BITS(input int line_words);
    return 32 * line_words;
  endfunction

  // True when a byte address falls inside [base, base + 4*size_words).
  // Evaluated in 34 bits so a window that touches the top of the address
  // space does not wrap.
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input int unsigned size_words);
    logic [33:0] lo;
    logic [33:0] hi;
    lo = {2'b00, base};
    hi = lo + ({2'b00, 32'(size_words)} << 2);
    return ({2'b00, addr} >= lo) && ({2'b00, addr} < hi);
  endfunction

endpackage

// File: rtl/line_fill_if.sv
// Refill port bundle: cache-side request/response plus the word-RAM side.
interface line_fill_if #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 12
);
  logic                    req_i;
  logic [31:0]             addr_i;
  logic                    valid_o;
  logic [32*LINE_WORDS-1:0] line_o;
  logic                    err_o;
  logic                    busy_o;
  logic                    ram_re_o;
  logic [ADDR_W-1:0]       ram_add_o;
  logic [31:0]             ram_d_i;
  logic [31:0]             fill_cnt_o;

  // Responder view.
  modport slave (
    input  req_i, addr_i, ram_d_i,
    output valid_o, line_o, err_o, busy_o, ram_re_o, ram_add_o, fill_cnt_o
  );

  // Requester + RAM model view.
  modport master (
    output req_i, addr_i, ram_d_i,
    input  valid_o, line_o, err_o, busy_o, ram_re_o, ram_add_o, fill_cnt_o
  );
endinterface

// File: rtl/line_fill_responder.sv
// Line refill responder: reads LINE_WORDS words from a 1-cycle-latency word
// RAM and returns them as one line with a single-cycle valid pulse.
module line_fill_responder
  import rv32i_mem_pkg::*;
#(
  parameter int          LINE_WORDS  = 4,
  parameter int          ADDR_W      = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned SIZE        = 4096,
  parameter int          WAIT_STATES = 0
) (
  input logic       clk_i,
  input logic       resetn_i,
  line_fill_if.slave bus
);

  localparam int LB = LINE_BITS(LINE_WORDS);
  localparam int KW = $clog2(LINE_WORDS);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_WORDS - 1);

  fill_state_e                   r_state, w_next;
  logic [ADDR_W-1:0]             r_base;
  logic [KW-1:0]                 r_k;
  logic [31:0]                   r_wcnt;
  logic                          r_err;
  logic                          r_cap_vld;
  logic [KW-1:0]                 r_cap_idx;
  logic [LINE_WORDS-1:0][31:0]   r_line;
  logic [31:0]                   r_fill_cnt;

  logic                          w_in_win;
  logic [ADDR_W-1:0]             w_base;
  logic                          w_last_k;
  logic                          w_wait_done;

  assign w_in_win    = in_window(bus.addr_i, BASE_ADDR, SIZE);
  // Word offset into the window, aligned down to the line start.
  assign w_base      = ADDR_W'((bus.addr_i - BASE_ADDR) >> 2) & LINE_MASK;
  assign w_last_k    = (r_k == KW'(LINE_WORDS - 1));
  assign w_wait_done = (r_wcnt == 32'(WAIT_STATES - 1));

  // State register.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  // Next-state and output decode.
  always_comb begin
    w_next         = r_state;
    bus.valid_o    = 1'b0;
    bus.err_o      = 1'b0;
    bus.busy_o     = (r_state != S_IDLE);
    bus.ram_re_o   = 1'b0;
    bus.ram_add_o  = '0;
    bus.line_o     = LB'(r_line);
    bus.fill_cnt_o = r_fill_cnt;
    case (r_state)
      S_IDLE: begin
        if (bus.req_i) begin
          if (!w_in_win)            w_next = S_RESP;
          else if (WAIT_STATES > 0) w_next = S_WAIT;
          else                      w_next = S_READ;
        end
      end
      S_WAIT:  if (w_wait_done) w_next = S_READ;
      S_READ: begin
        bus.ram_re_o  = 1'b1;
        bus.ram_add_o = r_base | ADDR_W'(r_k);
        if (w_last_k) w_next = S_DRAIN;
      end
      S_DRAIN: w_next = S_RESP;
      S_RESP: begin
        bus.valid_o = 1'b1;
        bus.err_o   = r_err;
        w_next      = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch, counters, and line assembly. Read data lands one cycle
  // after issue, so the capture slot trails the issue index by one cycle.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_base     <= '0;
      r_k        <= '0;
      r_wcnt     <= '0;
      r_err      <= 1'b0;
      r_cap_vld  <= 1'b0;
      r_cap_idx  <= '0;
      r_line     <= '0;
      r_fill_cnt <= '0;
    end else begin
      r_cap_vld <= (r_state == S_READ);
      r_cap_idx <= r_k;
      if (r_cap_vld) r_line[r_cap_idx] <= bus.ram_d_i;
      case (r_state)
        S_IDLE: begin
          if (bus.req_i) begin
            r_base <= w_base;
            r_k    <= '0;
            r_wcnt <= '0;
            r_err  <= !w_in_win;
            if (!w_in_win) r_line <= '0;
          end
        end
        S_WAIT:  r_wcnt <= r_wcnt + 32'd1;
        S_READ:  r_k    <= r_k + KW'(1);
        S_RESP:  if (!r_err) r_fill_cnt <= r_fill_cnt + 32'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_line_fill_responder.sv
// Scoreboard bench: two responders (0 and 3 wait states) on one clock, a
// shared word-RAM image, and per-instance queues of expected lines and RAM
// reads checked by a free-running monitor.
module tb_line_fill_responder;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  line_fill_if #(.LINE_WORDS(4), .ADDR_W(12)) bus0 ();
  line_fill_if #(.LINE_WORDS(4), .ADDR_W(12)) bus1 ();

  line_fill_responder #(.LINE_WORDS(4), .ADDR_W(12), .BASE_ADDR(32'h0),
                        .SIZE(4096), .WAIT_STATES(0)) dut0 (
    .clk_i(clk), .resetn_i(resetn), .bus(bus0));

  line_fill_responder #(.LINE_WORDS(4), .ADDR_W(12), .BASE_ADDR(32'h0),
                        .SIZE(4096), .WAIT_STATES(3)) dut1 (
    .clk_i(clk), .resetn_i(resetn), .bus(bus1));

  // Synchronous word RAM models, 1-cycle read latency.
  logic [31:0] mem [0:4095];
  logic [31:0] rd0 = '0, rd1 = '0;
  always @(posedge clk) if (bus0.ram_re_o) rd0 <= mem[bus0.ram_add_o];
  always @(posedge clk) if (bus1.ram_re_o) rd1 <= mem[bus1.ram_add_o];
  assign bus0.ram_d_i = rd0;
  assign bus1.ram_d_i = rd1;

  typedef struct packed {
    logic [127:0] line;
    logic         err;
    logic [31:0]  cyc;
  } exp_t;
  typedef struct packed {
    logic [11:0] a;
    logic [31:0] cyc;
  } rexp_t;

  exp_t  sb0[$], sb1[$];
  rexp_t rq0[$], rq1[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] exp_line(input logic [31:0] addr);
    logic [127:0] l;
    int b;
    b = int'((addr >> 2) & 32'hFFFF_FFFC);
    for (int k = 0; k < 4; k++) l[32*k +: 32] = mem[b + k];
    return l;
  endfunction

  // Record expected response and RAM reads for a request accepted in cycle a.
  task automatic push_exp(input int d, input logic [31:0] addr, input int a);
    int   w;
    exp_t e;
    w = (d == 0) ? 0 : 3;
    if (addr < 32'h4000) begin
      e = '{line: exp_line(addr), err: 1'b0, cyc: 32'(a + w + 4 + 2)};
      for (int k = 0; k < 4; k++) begin
        if (d == 0) rq0.push_back('{a: 12'((addr >> 2) & 32'hFFC) + 12'(k), cyc: 32'(a + 1 + w + k)});
        else        rq1.push_back('{a: 12'((addr >> 2) & 32'hFFC) + 12'(k), cyc: 32'(a + 1 + w + k)});
      end
    end else begin
      e = '{line: '0, err: 1'b1, cyc: 32'(a + 1)};
    end
    if (d == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    while (((d == 0) ? bus0.busy_o : bus1.busy_o) && n < 100) begin
      tick(1);
      n++;
    end
    if (n >= 100) begin
      checks++; failures++;
      $display("FAIL wait_idle_timeout dut=%0d actual=busy required=idle", d);
    end
  endtask

  // Issue one request; with hold set, req_i is left high on return.
  task automatic issue(input int d, input logic [31:0] addr, input bit hold, output int a);
    wait_idle(d);
    if (d == 0) begin bus0.req_i = 1'b1; bus0.addr_i = addr; end
    else        begin bus1.req_i = 1'b1; bus1.addr_i = addr; end
    a = cyc;
    push_exp(d, addr, a);
    if (!hold) begin
      tick(1);
      if (d == 0) bus0.req_i = 1'b0;
      else        bus1.req_i = 1'b0;
    end
  endtask

  task automatic mon(input int d, input logic vld, input logic err,
                     input logic [127:0] line, input logic re, input logic [11:0] ra);
    exp_t  e;
    rexp_t r;
    if (vld) begin
      if ((d == 0 ? sb0.size() : sb1.size()) == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_valid dut=%0d actual=cycle%0d required=no_valid", d, cyc);
      end else begin
        e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
        chk($sformatf("line_dut%0d", d), line, e.line);
        chk($sformatf("err_dut%0d", d), 128'(err), 128'(e.err));
        chk($sformatf("valid_cycle_dut%0d", d), 128'(cyc), 128'(e.cyc));
      end
    end else begin
      chk($sformatf("err_without_valid_dut%0d", d), 128'(err), 128'(0));
    end
    if (re) begin
      if ((d == 0 ? rq0.size() : rq1.size()) == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_ram_re dut=%0d actual=addr%0d required=no_read", d, ra);
      end else begin
        r = (d == 0) ? rq0.pop_front() : rq1.pop_front();
        chk($sformatf("ram_add_dut%0d", d), 128'(ra), 128'(r.a));
        chk($sformatf("ram_re_cycle_dut%0d", d), 128'(cyc), 128'(r.cyc));
      end
    end
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      mon(0, bus0.valid_o, bus0.err_o, bus0.line_o, bus0.ram_re_o, bus0.ram_add_o);
      mon(1, bus1.valid_o, bus1.err_o, bus1.line_o, bus1.ram_re_o, bus1.ram_add_o);
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"},    128'(bus0.valid_o),    128'(0));
    chk({tag, "_err"},      128'(bus0.err_o),      128'(0));
    chk({tag, "_busy"},     128'(bus0.busy_o),     128'(0));
    chk({tag, "_ram_re"},   128'(bus0.ram_re_o),   128'(0));
    chk({tag, "_ram_add"},  128'(bus0.ram_add_o),  128'(0));
    chk({tag, "_line"},     bus0.line_o,           128'(0));
    chk({tag, "_fill_cnt"}, 128'(bus0.fill_cnt_o), 128'(0));
  endtask

  initial begin
    int a;
    int n;
    for (int i = 0; i < 4096; i++) mem[i] = 32'hA500_0000 | 32'(i);
    mem[16] = 32'h11; mem[17] = 32'h22; mem[18] = 32'h33; mem[19] = 32'h44;
    bus0.req_i = 1'b0; bus0.addr_i = '0;
    bus1.req_i = 1'b0; bus1.addr_i = '0;

    tick(3);
    chk_all_zero("reset");
    chk("reset_busy_dut1", 128'(bus1.busy_o), 128'(0));
    resetn = 1'b1;
    tick(2);

    // W=0 fill of the line holding 0x48.
    issue(0, 32'h0000_0048, 1'b0, a);
    wait_idle(0);
    chk("line_0x48_hand", bus0.line_o, 128'h00000044_00000033_00000022_00000011);
    chk("fill_cnt_after_fill", 128'(bus0.fill_cnt_o), 128'(1));

    // Out-of-window request.
    issue(0, 32'h0001_0000, 1'b0, a);
    wait_idle(0);
    chk("fill_cnt_after_err", 128'(bus0.fill_cnt_o), 128'(1));
    chk("line_after_err", bus0.line_o, 128'(0));

    // Three wait states, same line.
    issue(1, 32'h0000_0048, 1'b0, a);
    wait_idle(1);
    chk("fill_cnt_dut1", 128'(bus1.fill_cnt_o), 128'(1));

    // Reset during READ: only the first RAM read is ever seen.
    tick(1);
    bus0.req_i = 1'b1; bus0.addr_i = 32'h0000_0040; a = cyc;
    rq0.push_back('{a: 12'd16, cyc: 32'(a + 1)});
    tick(1);
    bus0.req_i = 1'b0;
    tick(1);
    resetn = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    tick(2);
    resetn = 1'b1;
    tick(10);
    chk("no_fill_after_reset", 128'(bus0.fill_cnt_o), 128'(0));

    // Back-to-back with req_i held; addr changes mid-fill are ignored.
    issue(0, 32'h0000_0048, 1'b1, a);
    push_exp(0, 32'h0000_0080, a + 7);
    push_exp(0, 32'h0000_0100, a + 14);
    tick(2);  bus0.addr_i = 32'h0000_0080;
    tick(7);  bus0.addr_i = 32'h0000_0100;
    tick(7);  bus0.addr_i = 32'h0000_7777;
    tick(5);  bus0.req_i = 1'b0;
    wait_idle(0);
    chk("fill_cnt_b2b", 128'(bus0.fill_cnt_o), 128'(3));

    n = 0;
    while ((sb0.size() + sb1.size() + rq0.size() + rq1.size()) != 0 && n < 200) begin
      tick(1);
      n++;
    end
    chk("pending_expectations", 128'(sb0.size() + sb1.size() + rq0.size() + rq1.size()), 128'(0));
    tick(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
